spi_master_arbiter: RTL

Round-robin arbiter and transaction sequencer that shares one `spi_master_driver` between NREQ requesters. It accepts one byte-transfer request at a time, latches its data, and drives the driver's `start_i` and `data_in_bi`. It then tracks `busy_o` through the transfer and returns the received byte to the granted requester with a one-cycle done pulse. It sits between the bus-side peripheral logic and `spi_master_driver`.

---
 rtl/spi_arb_pkg.sv | 23 ++
 rtl/spi_rr_picker.sv | 30 +++
 rtl/spi_master_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter: FSM state encoding,
// default sizing and a constant-evaluable ceil(log2) helper.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_XFER      = 2'd2,
    ST_DONE      = 2'd3
  } arb_state_e;

  localparam int DEFAULT_DW      = 8;
  localparam int DEFAULT_NREQ    = 4;
  localparam int DEFAULT_TIMEOUT = 1024;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) res++;
    return res;
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker: searches req starting one past 'last',
// wrapping modulo NREQ, and reports the winner one-hot, as an index and via 'any'.
module spi_rr_picker
  import spi_arb_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int IW   = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] sel,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Offset k = NREQ lands back on 'last' itself, so it is searched last.
  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && req[(int'(last) + k) % NREQ]) begin
        any = 1'b1;
        idx = IW'((int'(last) + k) % NREQ);
      end
    end
    if (any) sel[idx] = 1'b1;
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master driver between NREQ requesters.
// Optional watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = DEFAULT_NREQ,
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] req_data_bi,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic [DW-1:0]      rsp_data_bo,
  output logic               err_o,
  output logic               arb_busy_o,
  output logic               m_start_o,
  output logic [DW-1:0]      m_data_bo,
  input  logic               m_busy_i,
  input  logic [DW-1:0]      m_data_bi
);

  localparam int IW = (NREQ > 1) ? clog2(NREQ) : 1;

  // Handshake: a requester holds req_i high until it sees its one-cycle gnt_o
  // pulse (data latched at that edge); done_o is a one-cycle pulse with
  // rsp_data_bo/err_o valid alongside. Requests are only sampled in IDLE.
  arb_state_e      state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            start_q, start_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [DW-1:0]   rsp_q, rsp_d;

  logic [NREQ-1:0] pick_sel;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  spi_rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req  (req_i),
    .last (last_q),
    .sel  (pick_sel),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          timeout_hit;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign err_o       = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    idx_d    = idx_q;
    gnt_d    = '0;
    done_d   = '0;
    start_d  = 1'b0;
    m_data_d = m_data_q;
    rsp_d    = rsp_q;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d  = ST_WAIT_BUSY;
          gnt_d    = pick_sel;
          start_d  = 1'b1;
          m_data_d = req_data_bi[int'(pick_idx)*DW +: DW];
          idx_d    = pick_idx;
          last_d   = pick_idx;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ST_WAIT_BUSY: begin
        if (m_busy_i) begin
          state_d = ST_XFER;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d       = ST_DONE;
          rsp_d         = '0;
          done_d[idx_q] = 1'b1;
          err_d         = 1'b1;
        end
        cnt_d = cnt_q + CW'(1);
`endif
      end
      ST_XFER: begin
        if (!m_busy_i) begin
          state_d       = ST_DONE;
          rsp_d         = m_data_bi;
          done_d[idx_q] = 1'b1;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d       = ST_DONE;
          rsp_d         = '0;
          done_d[idx_q] = 1'b1;
          err_d         = 1'b1;
        end
        cnt_d = cnt_q + CW'(1);
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // last resets to NREQ-1 so requester 0 has first priority out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      last_q   <= IW'(NREQ - 1);
      idx_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      m_data_q <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      start_q  <= start_d;
      m_data_q <= m_data_d;
      rsp_q    <= rsp_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign m_start_o   = start_q;
  assign m_data_bo   = m_data_q;
  assign rsp_data_bo = rsp_q;
  assign arb_busy_o  = (state_q != ST_IDLE);

endmodule
